// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Mode 3 is reserved and behaves like no parity.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic [3:0] data_bits(input logic [1:0] cfg_bits);
    return 4'd5 + {2'b00, cfg_bits};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] cfg_bits);
    case (cfg_bits)
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic par_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: strobes on the last clock of every bit while a frame runs.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_m1,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;

  assign strobe = run && (cnt == div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame latched divisor, data width, parity and stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       cfg_bits,
  input  logic [1:0]       cfg_par,
  input  logic             cfg_stop2,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  tx_state_e        state;
  logic [DIV_W-1:0] div_m1_q;
  logic [DIV_W-1:0] div_eff;
  logic [1:0]       bits_q;
  logic [1:0]       par_q;
  logic             stop2_q;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       data_sh;
  logic             par_bit;
  logic             rdy_en;
  logic             strobe;
  logic             last_data;
  logic             last_stop;
  logic             xfer;

  assign div_eff    = (div == '0) ? DIV_W'(1) : div;
  assign last_data  = ({1'b0, bit_idx} == (data_bits(bits_q) - 4'd1));
  assign last_stop  = (stop_idx == stop2_q);
  assign frame_done = (state == ST_STOP) && strobe && last_stop;
  // rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready   = rdy_en && ((state == ST_IDLE) || frame_done);
  assign xfer       = in_valid && in_ready;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state != ST_IDLE),
    .restart (xfer),
    .div_m1  (div_m1_q),
    .strobe  (strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      rdy_en   <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      div_m1_q <= DIV_W'(DIV_RST - 1);
      bits_q   <= 2'd3;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (xfer) begin
        state    <= ST_START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        div_m1_q <= div_eff - 1'b1;
        bits_q   <= cfg_bits;
        par_q    <= cfg_par;
        stop2_q  <= cfg_stop2;
      end else if (strobe) begin
        case (state)
          ST_START: begin
            state <= ST_DATA;
            tx    <= data_sh[0];
          end
          ST_DATA: begin
            if (!last_data) begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_sh[0];
            end else if (par_on(par_q)) begin
              state <= ST_PARITY;
              tx    <= par_bit;
            end else begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
          ST_STOP: begin
            if (last_stop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Payload is masked to the frame width at acceptance and shifted out LSB first.
  always_ff @(posedge clk) begin
    if (xfer) begin
      data_sh <= in_data & data_mask(cfg_bits);
      par_bit <= (^(in_data & data_mask(cfg_bits))) ^ (cfg_par == PAR_ODD);
    end else if (strobe && ((state == ST_START) || (state == ST_DATA))) begin
      data_sh <= data_sh >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg against a bit-list frame model.
module tb_uart_tx_cfg;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] dv;
    logic [1:0]  bits;
    logic [1:0]  par;
    logic        s2;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] div = 16'd4;
  logic [1:0]  cfg_bits = 2'd3;
  logic [1:0]  cfg_par = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, tx, busy, frame_done;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DIV_W(16), .DIV_RST(434)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div        (div),
    .cfg_bits   (cfg_bits),
    .cfg_par    (cfg_par),
    .cfg_stop2  (cfg_stop2),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic frm_t mk(input logic [7:0] d, input int dv, input int b, input int p, input int s);
    frm_t f;
    f.data = d; f.dv = 16'(dv); f.bits = 2'(b); f.par = 2'(p); f.s2 = 1'(s);
    return f;
  endfunction

  function automatic frm_t rand_frm();
    return mk(8'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
  endfunction

  task automatic drive(input frm_t f);
    in_data = f.data; div = f.dv; cfg_bits = f.bits; cfg_par = f.par; cfg_stop2 = f.s2;
  endtask

  // Expected line levels, one entry per bit period.
  task automatic build(input frm_t f);
    int n;
    bit p;
    exp_q.delete();
    exp_q.push_back(1'b0);
    n = int'(f.bits) + 5;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(f.data[i]);
      p ^= f.data[i];
    end
    if (f.par == 2'd1) exp_q.push_back(p);
    else if (f.par == 2'd2) exp_q.push_back(~p);
    exp_q.push_back(1'b1);
    if (f.s2) exp_q.push_back(1'b1);
  endtask

  task automatic start(input frm_t f);
    int waited;
    drive(f);
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      total++; bad++;
      $display("FAIL start_timeout in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Called in cycle 1 of frame f; returns in the cycle after its last stop cycle.
  task automatic play(input frm_t f, input bit scramble, input bit has_next, input frm_t nxt);
    int d, len;
    build(f);
    d = (f.dv == 16'd0) ? 1 : int'(f.dv);
    len = exp_q.size() * d;
    for (int k = 1; k <= len; k++) begin
      if (k == 1) begin
        if (has_next) begin drive(nxt); in_valid = 1'b1; end
        else in_valid = 1'b0;
      end
      if (k == 2 && scramble) drive(rand_frm());
      if (busy === 1'b1) busy_cnt++;
      total++;
      if (tx !== exp_q[(k-1)/d]) begin
        bad++; $display("FAIL tx cyc=%0d got=%b want=%b data=%h", k, tx, exp_q[(k-1)/d], f.data);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL busy cyc=%0d got=%b want=1", k, busy);
      end
      total++;
      if (frame_done !== 1'(k == len)) begin
        bad++; $display("FAIL frame_done cyc=%0d got=%b want=%b", k, frame_done, k == len);
      end
      total++;
      if (in_ready !== 1'(k == len)) begin
        bad++; $display("FAIL in_ready cyc=%0d got=%b want=%b", k, in_ready, k == len);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string nm);
    total++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
      bad++;
      $display("FAIL idle_%s tx/busy/rdy/done got=%b%b%b%b want=1010", nm, tx, busy, in_ready, frame_done);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1000) begin
      bad++; $display("FAIL reset_async got=%b%b%b%b want=1000", tx, busy, in_ready, frame_done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release_early in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    check_idle("after_reset");
  endtask

  task automatic test_vectors();
    frm_t f;
    f = mk(8'hA5, 4, 3, 0, 0); start(f); play(f, 1'b0, 1'b0, f); check_idle("8n1");
    f = mk(8'h55, 2, 2, 1, 0); start(f); play(f, 1'b0, 1'b0, f); check_idle("7e1");
    f = mk(8'h1F, 3, 0, 2, 1); start(f); play(f, 1'b0, 1'b0, f); check_idle("5o2");
    f = mk(8'hE0, 3, 0, 1, 0); start(f); play(f, 1'b0, 1'b0, f); check_idle("5e1_hi");
    f = mk(8'h6B, 0, 3, 3, 1); start(f); play(f, 1'b0, 1'b0, f); check_idle("div0_par3");
  endtask

  task automatic test_back_to_back();
    frm_t f1, f2;
    f1 = mk(8'hA5, 4, 3, 0, 0);
    f2 = mk(8'h3C, 4, 3, 0, 0);
    start(f1);
    busy_cnt = 0;
    play(f1, 1'b0, 1'b1, f2);
    play(f2, 1'b0, 1'b0, f2);
    total++;
    if (busy_cnt != 80) begin
      bad++; $display("FAIL b2b_busy_cycles got=%0d want=80", busy_cnt);
    end
    check_idle("b2b");
  endtask

  task automatic test_midframe_cfg();
    frm_t f1, f2;
    f1 = mk(8'hC6, 3, 1, 2, 0);
    f2 = mk(8'h39, 5, 3, 1, 1);
    start(f1);
    play(f1, 1'b1, 1'b0, f1);
    check_idle("mid1");
    start(f2);
    play(f2, 1'b1, 1'b0, f2);
    check_idle("mid2");
  endtask

  task automatic test_random();
    frm_t f, n;
    bit chain;
    f = rand_frm();
    start(f);
    for (int i = 0; i < 24; i++) begin
      chain = 1'($urandom_range(0, 1));
      n = rand_frm();
      if (chain) begin
        play(f, 1'b0, 1'b1, n);
      end else begin
        play(f, 1'b1, 1'b0, n);
        check_idle("rand");
        start(n);
      end
      f = n;
    end
    play(f, 1'b0, 1'b0, f);
    check_idle("rand_end");
  endtask

  task automatic test_reset_mid_frame();
    frm_t f;
    f = mk(8'h0F, 4, 3, 1, 1);
    start(f);
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pre busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1000) begin
      bad++; $display("FAIL midrst_async got=%b%b%b%b want=1000", tx, busy, in_ready, frame_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      check_idle("post_rst");
      @(posedge clk); #1;
    end
    f = mk(8'h96, 2, 3, 2, 0);
    start(f);
    play(f, 1'b0, 1'b0, f);
    check_idle("post_rst_frame");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_midframe_cfg();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter: DIV_W, 16, width of the runtime baud divisor.
REQ-002 Parameter: DIV_RST, 434, divisor loaded at reset (50 MHz / 115200).
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: div  input  DIV_W  clock cycles per bit; value 0 SHALL be treated as 1.
REQ-006 Port: cfg_bits  input  2  data bits per frame (0=5, 1=6, 2=7, 3=8).
REQ-007 Port: cfg_par  input  2  parity mode (0=none, 1=even, 2=odd, 3=treated as none).
REQ-008 Port: cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 Port: in_valid  input  1  byte offered.
REQ-010 Port: in_data  input  8  byte; bits at or above the data-bit count are ignored.
REQ-011 Port: in_ready  output  1  block accepts a byte this cycle.
REQ-012 Port: tx  output  1  serial line, idle high.
REQ-013 Port: busy  output  1  a frame is in progress.
REQ-014 Port: frame_done  output  1  one-cycle pulse on the last cycle of the last stop bit.

Function
REQ-015 A transfer SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-016 At a transfer, the block SHALL latch in_data, div, cfg_bits, cfg_par and cfg_stop2; later config changes SHALL NOT affect the frame in flight.
REQ-017 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE->START on transfer.
- START->DATA after one bit period.
- DATA->PARITY, or DATA->STOP when parity is none, after the last data bit.
- PARITY->STOP after one bit period.
- STOP->IDLE, or STOP->START on a transfer, after 1 or 2 bit periods.
REQ-018 tx SHALL be registered, and the start bit SHALL appear on the cycle after the transfer.
REQ-019 Each bit SHALL last exactly div clock cycles.
REQ-020 Data SHALL be sent LSB first.
REQ-021 The parity bit SHALL be the XOR of the sent data bits for even, and its inverse for odd.
REQ-022 Frame length SHALL be (1 + N + P + S) * div cycles, where N is the data-bit count, P is the parity bit (0 or 1) and S is the stop-bit count.
REQ-023 in_ready SHALL be high in IDLE and on the final cycle of the last stop bit, and low otherwise.
REQ-024 A transfer on that final stop cycle SHALL start the next start bit immediately, with no idle cycle between frames.
REQ-025 busy SHALL be high from the cycle after a transfer until the cycle after the last stop bit, and SHALL stay high across back-to-back frames.
REQ-026 in_valid deasserting without a transfer SHALL have no effect.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state = IDLE, tx = 1, busy = 0, frame_done = 0, in_ready = 0, all counters = 0.
REQ-028 A frame in progress SHALL be abandoned with tx forced high and no partial bits resumed.
REQ-029 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, the parity-mode encoding constants and the cfg_bits decode function.
REQ-031 Sub-module uart_baud_cnt SHALL generate the per-bit end-of-period strobe from the latched divisor, restarting at each frame start.

Verification
REQ-032 div=4, 8N1, 0xA5: tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; 40 cycles total; frame_done on cycle 40.
REQ-033 div=2, 7E1, 0x55: tx = 0, 1,0,1,0,1,0,1, parity 0, stop 1; 20 cycles.
REQ-034 div=3, 5O2, 0x1F: tx = 0, 1,1,1,1,1, parity 0, stop 1,1; 27 cycles; bits 7:5 ignored.
REQ-035 in_valid held high with two bytes at div=4, 8N1: second start bit begins on the cycle after the first frame's last stop cycle; busy stays high for 80 cycles.
REQ-036 Change div and cfg mid-frame: the current frame keeps the latched settings and the next frame uses the new ones.
REQ-037 rst_n low during DATA: tx = 1 and busy = 0 with no clock edge; in_ready = 1 after the first edge once rst_n is released.
